and_gate: RTL and testbench

- Bitwise two-input AND primitive used as a leaf logic cell and as a registered AND stage in datapaths.
- Provides a combinational result `y` for glue-logic use.
- Also provides a pipelined, valid-qualified copy `y_q` / `out_valid` with a reduction flag, for timing-closed paths.
- Single clock domain; no handshake back-pressure.

---
 rtl/and_gate_pkg.sv | 7 +
 rtl/and_gate_pipe_stage.sv | 29 ++
 rtl/and_gate.sv | 50 +++++
 tb/tb_and_gate.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/and_gate_pkg.sv
// Shared constants and types for the and_gate leaf cell and its pipeline.
package and_gate_pkg;
  localparam int MAX_WIDTH       = 64;
  localparam int MAX_PIPE_STAGES = 8;

  typedef logic [MAX_WIDTH-1:0] and_word_t;
endpackage

// File: rtl/and_gate_pipe_stage.sv
// One data+valid register stage; data only loads behind a valid, valid always loads.
module and_gate_pipe_stage
  import and_gate_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("and_gate_pipe_stage: WIDTH %0d out of range 1..%0d", WIDTH, MAX_WIDTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      q_vld <= 1'b0;
    end else begin
      q_vld <= d_vld;
      if (d_vld) q <= d;
    end
  end

endmodule

// File: rtl/and_gate.sv
// Bitwise AND: combinational y plus a valid-qualified, PIPE_STAGES-deep registered copy.
module and_gate
  import and_gate_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int PIPE_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic             y_all
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("and_gate: WIDTH %0d out of range 1..%0d", WIDTH, MAX_WIDTH);
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > MAX_PIPE_STAGES) begin : g_bad_stages
    $error("and_gate: PIPE_STAGES %0d out of range 1..%0d", PIPE_STAGES, MAX_PIPE_STAGES);
  end

  // Index 0 is the pipeline input; index PIPE_STAGES is the output stage.
  logic [PIPE_STAGES:0]            vld_pipe;
  logic [PIPE_STAGES:0][WIDTH-1:0] dat_pipe;

  assign y           = a & b;
  assign vld_pipe[0] = in_valid;
  assign dat_pipe[0] = a & b;

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
    and_gate_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .d     (dat_pipe[i]),
      .d_vld (vld_pipe[i]),
      .q     (dat_pipe[i+1]),
      .q_vld (vld_pipe[i+1])
    );
  end

  assign y_q       = dat_pipe[PIPE_STAGES];
  assign out_valid = vld_pipe[PIPE_STAGES];
  // Driven from the registered word regardless of out_valid.
  assign y_all     = &y_q;

endmodule

// File: tb/tb_and_gate.sv
// Scoreboard bench for and_gate across four width/depth configurations.
module tb_and_gate;
  import and_gate_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    and_word_t y;
    logic      all;
    int        due;
  } exp_t;

  exp_t sb[4][$];

  // id 0: W1 P1, id 1: W8 P3, id 2: W4 P2, id 3: W4 P3
  logic       r1, v1, ov1, ya1;
  logic [0:0] a1, b1, y1, yq1;
  logic       r8, v8, ov8, ya8;
  logic [7:0] a8, b8, y8, yq8;
  logic       r4, v4, ov4, ya4;
  logic [3:0] a4, b4, y4, yq4;
  logic       rr, vr, ovr, yar;
  logic [3:0] ar, br, yr, yqr;

  and_gate #(.WIDTH(1), .PIPE_STAGES(1)) u_d1 (
    .clk(clk), .rst(r1), .a(a1), .b(b1), .in_valid(v1),
    .y(y1), .y_q(yq1), .out_valid(ov1), .y_all(ya1));
  and_gate #(.WIDTH(8), .PIPE_STAGES(3)) u_d8 (
    .clk(clk), .rst(r8), .a(a8), .b(b8), .in_valid(v8),
    .y(y8), .y_q(yq8), .out_valid(ov8), .y_all(ya8));
  and_gate #(.WIDTH(4), .PIPE_STAGES(2)) u_d4 (
    .clk(clk), .rst(r4), .a(a4), .b(b4), .in_valid(v4),
    .y(y4), .y_q(yq4), .out_valid(ov4), .y_all(ya4));
  and_gate #(.WIDTH(4), .PIPE_STAGES(3)) u_dr (
    .clk(clk), .rst(rr), .a(ar), .b(br), .in_valid(vr),
    .y(yr), .y_q(yqr), .out_valid(ovr), .y_all(yar));

  task automatic check(input string name, input and_word_t act, input and_word_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input and_word_t y, input logic all, input int p);
    exp_t e;
    e.y   = y;
    e.all = all;
    e.due = cyc + p;
    sb[id].push_back(e);
  endtask

  // Reset discards anything that has not yet reached the output.
  task automatic flush(input int id);
    while (sb[id].size() > 0 && sb[id][$].due > cyc) void'(sb[id].pop_back());
  endtask

  task automatic mon(input int id, input logic ov, input and_word_t yq, input logic ya);
    exp_t e;
    if (sb[id].size() > 0 && sb[id][0].due < cyc) begin
      check($sformatf("missing_valid_%0d", id), and_word_t'(1'b0), and_word_t'(1'b1));
      void'(sb[id].pop_front());
    end
    if (ov === 1'b1) begin
      if (sb[id].size() == 0) begin
        check($sformatf("unexpected_valid_%0d", id), and_word_t'(ov), and_word_t'(1'b0));
      end else begin
        e = sb[id].pop_front();
        check($sformatf("y_q_%0d", id), yq, e.y);
        check($sformatf("y_all_%0d", id), and_word_t'(ya), and_word_t'(e.all));
        check($sformatf("latency_%0d", id), and_word_t'(cyc), and_word_t'(e.due));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ov1, and_word_t'(yq1), ya1);
    mon(1, ov8, and_word_t'(yq8), ya8);
    mon(2, ov4, and_word_t'(yq4), ya4);
    mon(3, ovr, and_word_t'(yqr), yar);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [0:0] ct_a [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [0:0] ct_b [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [0:0] ct_y [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] st_b [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

  initial begin
    {a1, b1, v1, a8, b8, v8, a4, b4, v4, ar, br, vr} = '0;
    {r1, r8, r4, rr} = 4'hF;
    step();
    step();
    check("rst_d1", and_word_t'({yq1, ov1, ya1}), and_word_t'(3'b000));
    check("rst_d8", and_word_t'({yq8, ov8, ya8}), and_word_t'(10'h000));
    check("rst_d4", and_word_t'({yq4, ov4, ya4}), and_word_t'(6'h00));
    check("rst_dr", and_word_t'({yqr, ovr, yar}), and_word_t'(6'h00));
    {r1, r8, r4, rr} = 4'h0;

    // Combinational truth table, independent of the clock.
    for (int i = 0; i < 4; i++) begin
      a1 = ct_a[i];
      b1 = ct_b[i];
      #1 check($sformatf("comb_y_%0d", i), and_word_t'(y1), and_word_t'(ct_y[i]));
      #9;
    end

    // Single-cycle latency on the 1-bit, 1-stage instance.
    step();
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    push(0, 64'h1, 1'b1, 1);
    step();
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    step();
    check("hold_y_q_d1", and_word_t'(yq1), 64'h1);
    check("hold_ov_d1", and_word_t'(ov1), 64'h0);

    // Multi-bit through three stages.
    a8 = 8'hF0; b8 = 8'h3C; v8 = 1'b1;
    #1 check("comb_y_d8", and_word_t'(y8), 64'h30);
    push(1, 64'h30, 1'b0, 3);
    step();
    a8 = 8'hFF; b8 = 8'hFF;
    push(1, 64'hFF, 1'b1, 3);
    step();
    a8 = 8'h0F; b8 = 8'hF0;
    push(1, 64'h00, 1'b0, 3);
    step();
    v8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;

    // Streaming, back-to-back on the 4-bit, 2-stage instance.
    for (int i = 0; i < 4; i++) begin
      a4 = 4'hF; b4 = st_b[i]; v4 = 1'b1;
      push(2, and_word_t'(st_b[i]), 1'b0, 2);
      step();
    end
    v4 = 1'b0;
    // Last valid d8 result was 0; all-ones with in_valid low must not reach y_q.
    check("gate_y_q_d8", and_word_t'(yq8), 64'h00);
    check("gate_ov_d8", and_word_t'(ov8), 64'h0);
    check("gate_y_d8", and_word_t'(y8), 64'hFF);

    // Reset one cycle after a valid input drops it.
    ar = 4'hF; br = 4'hF; vr = 1'b1;
    push(3, 64'hF, 1'b1, 3);
    step();
    vr = 1'b0; rr = 1'b1;
    flush(3);
    #1 check("rst_mid_y", and_word_t'(yr), 64'hF);
    step();
    rr = 1'b0;
    check("rst_mid_y_q", and_word_t'(yqr), 64'h0);
    check("rst_mid_ov", and_word_t'(ovr), 64'h0);
    check("rst_mid_y_all", and_word_t'(yar), 64'h0);

    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < 4; i++)
      check($sformatf("sb_drain_%0d", i), and_word_t'(sb[i].size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
